// File: rtl/key_debounce_multi.sv
// key_debounce_multi: multi-channel push-button conditioner.
// Each key has its own two-flop synchroniser, debounce counter, hold counter
// and four-state FSM (IDLE, DEB_DN, HELD, DEB_UP).
// Outputs per key: debounced level, press/release strobes and a long-press strobe.
// Optional feature macro: KEY_REPEAT_EN. When it is defined, key_press auto-repeats
// every REPEAT_CYCLES while the key stays held after key_long has fired.
// Without the macro, no repeat counter exists and REPEAT_CYCLES is only range-checked.
//
// Handshake: none. All outputs are registered levels or single-cycle strobes
// with no back-pressure.
// Latency: a pin edge reaches key_press or key_release after 2 + DEB_CYCLES clocks.
// Long press: key_long fires LONG_CYCLES clocks after key_press.
module key_debounce_multi #(
    parameter int KEY_NUM       = 8,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic               CLK_50M,
    input  logic               RST_N,
    input  logic [KEY_NUM-1:0] KEY,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEB_DN = 2'd1,
        HELD   = 2'd2,
        DEB_UP = 2'd3
    } state_t;

    // The IDLE->DEB_DN step consumes one stable cycle.
    // DEB_DN exits when the count would reach DEB_CYCLES-1, so the
    // total is exactly DEB_CYCLES stable clocks after synchronisation.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 2);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    // Reject parameter sets the counters cannot represent.
    if (DEB_CYCLES < 2 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1 || CNT_W < 2 || CNT_W > 30 ||
        DEB_CYCLES > (1 << CNT_W) || LONG_CYCLES > (1 << CNT_W) ||
        REPEAT_CYCLES > (1 << CNT_W)) begin : g_param_err
        $error("key_debounce_multi: invalid cycle counts for CNT_W");
    end

    // Released pin value, used as the synchroniser reset value.
    localparam logic [KEY_NUM-1:0] PIN_RELEASED = {KEY_NUM{ACTIVE_LOW}};

    logic [KEY_NUM-1:0] sync1_q;
    logic [KEY_NUM-1:0] sync2_q;
    logic [KEY_NUM-1:0] pressed;

    // Two-flop synchroniser on every raw key pin.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= PIN_RELEASED;
            sync2_q <= PIN_RELEASED;
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
        end
    end

    // Polarity normalisation: 1 means pressed from here on.
    assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

    for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] hcnt_q;
        logic             long_done_q;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             long_q;
`ifdef KEY_REPEAT_EN
        logic [CNT_W-1:0] rcnt_q;
`endif

        // Per-key debounce FSM with registered level and strobes.
        always_ff @(posedge CLK_50M or negedge RST_N) begin
            if (!RST_N) begin
                state_q     <= IDLE;
                cnt_q       <= '0;
                hcnt_q      <= '0;
                long_done_q <= 1'b0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                long_q      <= 1'b0;
`ifdef KEY_REPEAT_EN
                rcnt_q      <= '0;
`endif
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                case (state_q)
                    IDLE: begin
                        level_q <= 1'b0;
                        if (pressed[g]) begin
                            state_q <= DEB_DN;
                            cnt_q   <= '0;
                        end
                    end
                    DEB_DN: begin
                        if (!pressed[g]) begin
                            // Bounce rejected before acceptance.
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == DEB_LAST) begin
                            state_q     <= HELD;
                            cnt_q       <= '0;
                            hcnt_q      <= '0;
                            long_done_q <= 1'b0;
                            level_q     <= 1'b1;
                            press_q     <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    HELD: begin
                        level_q <= 1'b1;
                        // Hold counter saturates. The long strobe fires once at saturation.
                        if (hcnt_q != LONG_LAST) begin
                            hcnt_q <= hcnt_q + CNT_ONE;
                        end else if (!long_done_q) begin
                            long_q      <= 1'b1;
                            long_done_q <= 1'b1;
                        end
`ifdef KEY_REPEAT_EN
                        if (long_done_q) begin
                            if (rcnt_q == REP_LAST) begin
                                press_q <= 1'b1;
                                rcnt_q  <= '0;
                            end else begin
                                rcnt_q <= rcnt_q + CNT_ONE;
                            end
                        end
`endif
                        if (!pressed[g]) begin
                            state_q <= DEB_UP;
                            cnt_q   <= '0;
                        end
                    end
                    DEB_UP: begin
                        level_q <= 1'b1;
                        if (pressed[g]) begin
                            // A bounce during release resumes the hold.
                            // The hold count and the long-fired flag are kept.
                            state_q <= HELD;
                            cnt_q   <= '0;
                        end else if (cnt_q == DEB_LAST) begin
                            state_q     <= IDLE;
                            cnt_q       <= '0;
                            hcnt_q      <= '0;
                            long_done_q <= 1'b0;
                            level_q     <= 1'b0;
                            release_q   <= 1'b1;
`ifdef KEY_REPEAT_EN
                            rcnt_q      <= '0;
`endif
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end

        assign key_level[g]   = level_q;
        assign key_press[g]   = press_q;
        assign key_release[g] = release_q;
        assign key_long[g]    = long_q;
    end

endmodule
